// File: rtl/nave_ctrl_pkg.sv
// Shared definitions for the paddle (nave) controller and its neighbours.
//   nave_state_t : serve FSM states (ball attached / ball in play)
//   nave_dir_t   : decoded horizontal key direction
//   KEY_*        : bit indices into the debounced keysout bus
//   key_dir()    : right/left key pair -> direction (both or none -> DIR_NONE)
package nave_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_SERVE = 1'b0,
    ST_PLAY  = 1'b1
  } nave_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } nave_dir_t;

  localparam int KEY_DIR   = 0;
  localparam int KEY_ESQ   = 1;
  localparam int KEY_LANCA = 2;

  function automatic nave_dir_t key_dir(input logic right, input logic left);
    if (right && !left)      return DIR_RIGHT;
    else if (left && !right) return DIR_LEFT;
    else                     return DIR_NONE;
  endfunction

endpackage

// File: rtl/nave_ctrl_vel.sv
// Paddle speed ramp.
//   Counts frame ticks with the same direction held; every ACCEL_TICKS such
//   ticks the speed grows by one up to SPEED_MAX. Releasing, pressing both
//   keys or reversing direction drops the speed back to SPEED_MIN.
// Ports
//   CLOCK_50  in   clock
//   reset     in   asynchronous active-low reset
//   restart   in   synchronous restart (same values as reset)
//   tick      in   frame tick pulse
//   pausa     in   freeze level
//   dir       in   decoded key direction
//   vel       out  registered speed magnitude
//   step      out  displacement to apply on this tick (SPEED_MIN on a reversal)
module nave_ctrl_vel
  import nave_ctrl_pkg::*;
#(
  parameter int unsigned SPEED_MIN   = 2,
  parameter int unsigned SPEED_MAX   = 8,
  parameter int unsigned ACCEL_TICKS = 6
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       restart,
  input  logic       tick,
  input  logic       pausa,
  input  nave_dir_t  dir,
  output logic [3:0] vel,
  output logic [3:0] step
);

  localparam int unsigned HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [3:0] V_MIN = 4'(SPEED_MIN);
  localparam logic [3:0] V_MAX = 4'(SPEED_MAX);

  logic [HW-1:0] hold_cnt, hold_nx;
  logic [HW:0]   hold_inc;
  logic [3:0]    vel_nx;
  nave_dir_t     dir_mem, dir_nx;
  logic          moving, changed;

  always_comb begin
    moving   = (dir == DIR_RIGHT) || (dir == DIR_LEFT);
    // A reversal needs a remembered direction; starting from rest is a plain first hold tick.
    changed  = moving && (dir_mem != DIR_NONE) && (dir != dir_mem);
    step     = changed ? V_MIN : vel;
    hold_inc = {1'b0, hold_cnt} + (HW + 1)'(1);
    hold_nx  = hold_cnt;
    vel_nx   = vel;
    dir_nx   = dir_mem;
    if (tick && !pausa) begin
      dir_nx = dir;
      if (!moving || changed) begin
        hold_nx = '0;
        vel_nx  = V_MIN;
      end else if (hold_inc == (HW + 1)'(ACCEL_TICKS)) begin
        hold_nx = '0;
        vel_nx  = (vel < V_MAX) ? vel + 4'd1 : V_MAX;
      end else begin
        hold_nx = hold_inc[HW-1:0];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      vel      <= V_MIN;
      dir_mem  <= DIR_NONE;
    end else if (restart) begin
      hold_cnt <= '0;
      vel      <= V_MIN;
      dir_mem  <= DIR_NONE;
    end else begin
      hold_cnt <= hold_nx;
      vel      <= vel_nx;
      dir_mem  <= dir_nx;
    end
  end

endmodule

// File: rtl/nave_ctrl.sv
// Paddle (nave) controller for the breakout playfield.
//   Moves the paddle once per frame tick with held-key acceleration, keeps it
//   inside the screen for any runtime width, and runs the serve FSM that keeps
//   the ball attached until launch and returns to serve on ball loss.
// Ports
//   CLOCK_50       in   system clock
//   reset          in   asynchronous active-low reset
//   tick_frame     in   one-cycle pulse per video frame
//   keysout[3:0]   in   debounced keys: [0] right, [1] left, [2] launch, [3] unused
//   pausa          in   freeze motion, speed and FSM
//   reiniciarJogo  in   synchronous restart
//   perdeu         in   ball-lost pulse
//   largura_nave   in   current paddle width
//   x_nave         out  paddle left x
//   y_nave         out  paddle y (constant Y_POS)
//   iniciarBola    out  one-cycle launch pulse
//   bola_presa     out  ball attached (serve state)
//   vel_nave       out  current speed magnitude
module nave_ctrl
  import nave_ctrl_pkg::*;
#(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned X_START     = 320,
  parameter int unsigned Y_POS       = 410,
  parameter int unsigned SPEED_MIN   = 2,
  parameter int unsigned SPEED_MAX   = 8,
  parameter int unsigned ACCEL_TICKS = 6
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick_frame,
  input  logic [3:0] keysout,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       perdeu,
  input  logic [9:0] largura_nave,
  output logic [9:0] x_nave,
  output logic [9:0] y_nave,
  output logic       iniciarBola,
  output logic       bola_presa,
  output logic [3:0] vel_nave
);

  localparam logic [10:0] SW = 11'(SCREEN_W);

  nave_state_t state, state_nx;
  nave_dir_t   dir;
  logic        launch_prev, launch_edge, fire;
  logic [3:0]  step_vel;
  logic [10:0] x_w, larg_w, step_w, x_mov;
  logic [9:0]  x_nx;
  logic        unused_keys;

  assign unused_keys = keysout[3];
  assign dir         = key_dir(keysout[KEY_DIR], keysout[KEY_ESQ]);
  assign y_nave      = 10'(Y_POS);
  assign bola_presa  = (state == ST_SERVE);

  nave_ctrl_vel #(
    .SPEED_MIN   (SPEED_MIN),
    .SPEED_MAX   (SPEED_MAX),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) u_vel (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .restart  (reiniciarJogo),
    .tick     (tick_frame),
    .pausa    (pausa),
    .dir      (dir),
    .vel      (vel_nave),
    .step     (step_vel)
  );

  // Position: move first, then the width clamp overrides the result. The
  // right-edge limit of the move is the same bound as the clamp, so the clamp
  // alone enforces it.
  always_comb begin
    x_w    = {1'b0, x_nave};
    larg_w = {1'b0, largura_nave};
    step_w = 11'(step_vel);
    x_mov  = x_w;
    if (tick_frame && !pausa) begin
      if (dir == DIR_RIGHT)
        x_mov = x_w + step_w;
      else if (dir == DIR_LEFT)
        x_mov = (x_w >= step_w) ? x_w - step_w : '0;
    end
    if (larg_w >= SW)
      x_nx = '0;
    else if (x_mov > SW - larg_w)
      x_nx = 10'(SW - larg_w);
    else
      x_nx = x_mov[9:0];
  end

  always_comb begin
    launch_edge = tick_frame && !pausa && keysout[KEY_LANCA] && !launch_prev;
    state_nx    = state;
    fire        = 1'b0;
    case (state)
      ST_SERVE: if (launch_edge) begin
        state_nx = ST_PLAY;
        fire     = 1'b1;
      end
      ST_PLAY: if (perdeu && !pausa) state_nx = ST_SERVE;
      default: state_nx = ST_SERVE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      x_nave      <= 10'(X_START);
      state       <= ST_SERVE;
      iniciarBola <= 1'b0;
      launch_prev <= 1'b0;
    end else if (reiniciarJogo) begin
      x_nave      <= 10'(X_START);
      state       <= ST_SERVE;
      iniciarBola <= 1'b0;
      launch_prev <= 1'b0;
    end else begin
      x_nave      <= x_nx;
      state       <= state_nx;
      iniciarBola <= fire;
      if (tick_frame && !pausa) launch_prev <= keysout[KEY_LANCA];
    end
  end

endmodule

// File: tb/tb_nave_ctrl.sv
// Bench for nave_ctrl: directed scenarios followed by a randomized phase,
// every cycle compared against a behavioural model of the paddle rules.
module tb_nave_ctrl;

  localparam int W     = 640;
  localparam int XS    = 320;
  localparam int YP    = 410;
  localparam int VMIN  = 2;
  localparam int VMAX  = 8;
  localparam int ACCEL = 6;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       tick_frame = 1'b0;
  logic [3:0] keysout = '0;
  logic       pausa = 1'b0;
  logic       reiniciarJogo = 1'b0;
  logic       perdeu = 1'b0;
  logic [9:0] largura_nave = 10'd80;
  logic [9:0] x_nave, y_nave;
  logic       iniciarBola, bola_presa;
  logic [3:0] vel_nave;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: position, serve/play, previous launch key, current hold run
  int m_x, m_play, m_lp, m_inic;
  int m_run_len, m_run_dir, m_run_change;
  logic [9:0] lg_cur;
  int sv_x, sv_v;

  nave_ctrl #(
    .SCREEN_W    (W),
    .X_START     (XS),
    .Y_POS       (YP),
    .SPEED_MIN   (VMIN),
    .SPEED_MAX   (VMAX),
    .ACCEL_TICKS (ACCEL)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .tick_frame    (tick_frame),
    .keysout       (keysout),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .perdeu        (perdeu),
    .largura_nave  (largura_nave),
    .x_nave        (x_nave),
    .y_nave        (y_nave),
    .iniciarBola   (iniciarBola),
    .bola_presa    (bola_presa),
    .vel_nave      (vel_nave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Speed after c counted hold ticks: one step per ACCEL ticks, saturating.
  function automatic int m_vel();
    int c, v;
    c = m_run_len - m_run_change;
    v = VMIN + c / ACCEL;
    return (v > VMAX) ? VMAX : v;
  endfunction

  task automatic model_reset();
    m_x = XS; m_play = 0; m_lp = 0; m_inic = 0;
    m_run_len = 0; m_run_dir = 0; m_run_change = 0;
  endtask

  task automatic model_step(input logic tk, input logic [3:0] k, input logic ps,
                            input logic pd, input logic [9:0] lg, input logic rs);
    int d, mv, nx, inic, lgi;
    if (rs) begin
      model_reset();
      return;
    end
    d    = (k[0] && !k[1]) ? 1 : (k[1] && !k[0]) ? 2 : 0;
    nx   = m_x;
    inic = 0;
    lgi  = int'(lg);
    if (tk && !ps) begin
      if (d == 0) begin
        m_run_len = 0; m_run_dir = 0; m_run_change = 0;
      end else begin
        if (d == m_run_dir) begin
          mv = m_vel();
          m_run_len++;
        end else begin
          mv = VMIN;
          m_run_change = (m_run_dir != 0) ? 1 : 0;
          m_run_dir = d;
          m_run_len = 1;
        end
        nx = (d == 1) ? m_x + mv : ((m_x >= mv) ? m_x - mv : 0);
      end
    end
    if (lgi >= W) nx = 0;
    else if (nx + lgi > W) nx = W - lgi;
    if (m_play == 0) begin
      if (tk && !ps && k[2] && m_lp == 0) begin
        m_play = 1; inic = 1;
      end
    end else if (pd && !ps) begin
      m_play = 0;
    end
    if (tk && !ps) m_lp = k[2] ? 1 : 0;
    m_x = nx;
    m_inic = inic;
  endtask

  task automatic cyc(input logic tk, input logic [3:0] k, input logic ps,
                     input logic pd, input logic [9:0] lg, input logic rs);
    @(negedge CLOCK_50);
    tick_frame = tk; keysout = k; pausa = ps; perdeu = pd;
    largura_nave = lg; reiniciarJogo = rs;
    model_step(tk, k, ps, pd, lg, rs);
    @(posedge CLOCK_50);
    #1;
    chk("x_nave", 32'(x_nave), 32'(m_x));
    chk("y_nave", 32'(y_nave), 32'(YP));
    chk("vel_nave", 32'(vel_nave), 32'(m_vel()));
    chk("bola_presa", 32'(bola_presa), 32'(1 - m_play));
    chk("iniciarBola", 32'(iniciarBola), 32'(m_inic));
  endtask

  // one frame: tick cycle then two idle cycles with the same keys held
  task automatic ftick(input logic [3:0] k);
    cyc(1'b1, k, 1'b0, 1'b0, lg_cur, 1'b0);
    cyc(1'b0, k, 1'b0, 1'b0, lg_cur, 1'b0);
    cyc(1'b0, k, 1'b0, 1'b0, lg_cur, 1'b0);
  endtask

  initial begin
    lg_cur = 10'd80;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_x", 32'(x_nave), 32'd320);
    chk("rst_y", 32'(y_nave), 32'd410);
    chk("rst_presa", 32'(bola_presa), 32'd1);
    chk("rst_vel", 32'(vel_nave), 32'd2);
    chk("rst_inic", 32'(iniciarBola), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    model_reset();

    // idle ticks
    repeat (10) ftick(4'b0000);
    chk("idle_x", 32'(x_nave), 32'd320);
    chk("idle_vel", 32'(vel_nave), 32'd2);

    // acceleration: 6 ticks at 2, 6 at 3, then 4 -> 320+12+18+4
    repeat (13) ftick(4'b0001);
    chk("accel_x", 32'(x_nave), 32'd354);
    chk("accel_vel", 32'(vel_nave), 32'd4);

    // right edge saturation
    repeat (80) ftick(4'b0001);
    chk("edge_x", 32'(x_nave), 32'd560);
    chk("edge_vel", 32'(vel_nave), 32'd8);
    ftick(4'b0001);
    chk("edge_hold_x", 32'(x_nave), 32'd560);

    // left edge: clamp to x=1 via width, then one left tick -> 0
    ftick(4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 10'd639, 1'b0);
    chk("x_one", 32'(x_nave), 32'd1);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, lg_cur, 1'b0);
    ftick(4'b0010);
    chk("left_zero", 32'(x_nave), 32'd0);
    ftick(4'b0010);
    chk("left_stay", 32'(x_nave), 32'd0);

    // width change without tick
    lg_cur = 10'd40;
    repeat (120) ftick(4'b0001);
    chk("w40_x", 32'(x_nave), 32'd600);
    ftick(4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 10'd100, 1'b0);
    chk("w100_x", 32'(x_nave), 32'd540);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 10'd700, 1'b0);
    chk("w700_x", 32'(x_nave), 32'd0);
    lg_cur = 10'd80;
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, lg_cur, 1'b0);

    // launch / loss / held key
    cyc(1'b1, 4'b0100, 1'b0, 1'b0, lg_cur, 1'b0);
    chk("launch_pulse", 32'(iniciarBola), 32'd1);
    chk("launch_presa", 32'(bola_presa), 32'd0);
    cyc(1'b0, 4'b0100, 1'b0, 1'b0, lg_cur, 1'b0);
    chk("launch_once", 32'(iniciarBola), 32'd0);
    cyc(1'b0, 4'b0100, 1'b0, 1'b1, lg_cur, 1'b0);
    chk("lost_presa", 32'(bola_presa), 32'd1);
    repeat (5) ftick(4'b0100);
    chk("held_presa", 32'(bola_presa), 32'd1);
    ftick(4'b0000);
    cyc(1'b1, 4'b0100, 1'b0, 1'b0, lg_cur, 1'b0);
    chk("relaunch", 32'(iniciarBola), 32'd1);
    chk("relaunch_presa", 32'(bola_presa), 32'd0);

    // move during play, then pause
    repeat (8) ftick(4'b0001);
    chk("play_x", 32'(x_nave), 32'd18);
    sv_x = int'(x_nave);
    sv_v = int'(vel_nave);
    repeat (5) begin
      cyc(1'b1, 4'b0001, 1'b1, 1'b0, lg_cur, 1'b0);
      cyc(1'b0, 4'b0001, 1'b1, 1'b0, lg_cur, 1'b0);
    end
    cyc(1'b0, 4'b0001, 1'b1, 1'b1, lg_cur, 1'b0);
    chk("pause_x", 32'(x_nave), 32'(sv_x));
    chk("pause_vel", 32'(vel_nave), 32'(sv_v));
    chk("pause_presa", 32'(bola_presa), 32'd0);

    // restart mid-play
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, lg_cur, 1'b1);
    chk("restart_x", 32'(x_nave), 32'd320);
    chk("restart_vel", 32'(vel_nave), 32'd2);
    chk("restart_presa", 32'(bola_presa), 32'd1);
    chk("restart_inic", 32'(iniciarBola), 32'd0);

    // randomized phase
    for (int i = 0; i < 800; i++) begin
      logic       r_tk, r_ps, r_pd, r_rs;
      logic [3:0] r_k;
      logic [9:0] r_lg;
      r_tk = ($urandom_range(0, 2) == 0);
      r_ps = ($urandom_range(0, 7) == 0);
      r_pd = ($urandom_range(0, 9) == 0);
      r_rs = ($urandom_range(0, 199) == 0);
      r_k  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lg_cur = 10'($urandom_range(20, 700));
      else if ($urandom_range(0, 9) == 0) lg_cur = 10'd80;
      r_lg = lg_cur;
      cyc(r_tk, r_k, r_ps, r_pd, r_lg, r_rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
